cpu_control_multi: RTL and testbench

- Multi-cycle control unit for the MIPS-subset CPU. It supports the same instruction set as the single-cycle core: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal.
- It sequences a shared-ALU, single-memory datapath through the IF/ID/EXE/MEM/WB states, waiting on a memory ready handshake.
- A bounded wait counter flags a memory that never responds.

---
 rtl/cpu_ctrl_pkg.sv | 56 +++++
 rtl/cpu_ctrl_decode.sv | 65 ++++++
 rtl/cpu_control_multi.sv | 176 +++++++++++++++++
 tb/tb_cpu_control_multi.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// FSM states, ALU operations, mux select codes and instruction fields.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_JR  = 6'h08;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction decoder: op/fun to a one-hot instruction class,
// the ALU operation used in EXE, and the immediate extension mode.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fun,
  output logic       rtype_alu,
  output logic       shift,
  output logic       itype_alu,
  output logic       lw,
  output logic       sw,
  output logic       branch,
  output logic       j,
  output logic       jr,
  output logic       jal,
  output logic       illegal,
  output logic [3:0] aluc,
  output logic       sext
);

  always_comb begin
    rtype_alu = 1'b0;
    shift     = 1'b0;
    itype_alu = 1'b0;
    lw        = 1'b0;
    sw        = 1'b0;
    branch    = 1'b0;
    j         = 1'b0;
    jr        = 1'b0;
    jal       = 1'b0;
    illegal   = 1'b0;
    aluc      = ALUC_ADD;
    sext      = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fun)
          F_ADD: begin rtype_alu = 1'b1; aluc = ALUC_ADD; end
          F_SUB: begin rtype_alu = 1'b1; aluc = ALUC_SUB; end
          F_AND: begin rtype_alu = 1'b1; aluc = ALUC_AND; end
          F_OR:  begin rtype_alu = 1'b1; aluc = ALUC_OR;  end
          F_XOR: begin rtype_alu = 1'b1; aluc = ALUC_XOR; end
          F_SLL: begin shift = 1'b1; aluc = ALUC_SLL; end
          F_SRL: begin shift = 1'b1; aluc = ALUC_SRL; end
          F_SRA: begin shift = 1'b1; aluc = ALUC_SRA; end
          F_JR:  jr = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin itype_alu = 1'b1; aluc = ALUC_ADD; sext = 1'b1; end
      OP_ANDI: begin itype_alu = 1'b1; aluc = ALUC_AND; end
      OP_ORI:  begin itype_alu = 1'b1; aluc = ALUC_OR;  end
      OP_XORI: begin itype_alu = 1'b1; aluc = ALUC_XOR; end
      OP_LUI:  begin itype_alu = 1'b1; aluc = ALUC_LUI; end
      OP_LW:   begin lw = 1'b1; sext = 1'b1; end
      OP_SW:   begin sw = 1'b1; sext = 1'b1; end
      OP_BEQ:  begin branch = 1'b1; aluc = ALUC_SUB; sext = 1'b1; end
      OP_BNE:  begin branch = 1'b1; aluc = ALUC_SUB; sext = 1'b1; end
      OP_J:    j = 1'b1;
      OP_JAL:  jal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_multi.sv
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB) for a shared-ALU, single-memory
// datapath, with a bounded memory-wait counter that raises bus_err.
module cpu_control_multi
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] fun,
  input  logic       z,
  input  logic       mem_ready,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       sext,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic [2:0] state,
  output logic       bus_err,
  output logic       illegal
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic [7:0] cnt_nxt;
  logic       timeout;

  logic       is_rtype, is_shift, is_itype, is_lw, is_sw, is_branch;
  logic       is_j, is_jr, is_jal, is_illegal, is_bne, dec_sext;
  logic [3:0] dec_aluc;

  cpu_ctrl_decode u_decode (
    .op        (op),
    .fun       (fun),
    .rtype_alu (is_rtype),
    .shift     (is_shift),
    .itype_alu (is_itype),
    .lw        (is_lw),
    .sw        (is_sw),
    .branch    (is_branch),
    .j         (is_j),
    .jr        (is_jr),
    .jal       (is_jal),
    .illegal   (is_illegal),
    .aluc      (dec_aluc),
    .sext      (dec_sext)
  );

  assign is_bne  = (op == OP_BNE);
  assign timeout = (wait_cnt == WAIT_MAX) && !mem_ready;
  assign state   = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IF;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= cnt_nxt;
    end
  end

  // Counter only advances while parked in IF/MEM; any transition or timeout clears it.
  always_comb begin
    nxt_state = S_IF;
    cnt_nxt   = '0;
    wpc       = 1'b0;
    wir       = 1'b0;
    wmem      = 1'b0;
    wreg      = 1'b0;
    iord      = 1'b0;
    regrt     = 1'b0;
    m2reg     = 1'b0;
    jal       = 1'b0;
    sext      = dec_sext;
    shift     = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = SRCB_REG;
    aluc      = ALUC_ADD;
    pcsource  = PC_ALU;
    bus_err   = 1'b0;
    illegal   = 1'b0;
    case (cur_state)
      S_IF: begin
        alusrcb = SRCB_FOUR;
        if (mem_ready) begin
          wir       = 1'b1;
          wpc       = 1'b1;
          nxt_state = S_ID;
        end else if (timeout) begin
          bus_err = 1'b1;
        end else begin
          nxt_state = S_IF;
          cnt_nxt   = wait_cnt + 8'd1;
        end
      end
      S_ID: begin
        alusrcb = SRCB_BR;
        if (is_j || is_jal) begin
          wpc      = 1'b1;
          pcsource = PC_JUMP;
          wreg     = is_jal;
          jal      = is_jal;
        end else if (is_jr) begin
          wpc      = 1'b1;
          pcsource = PC_REG;
        end else if (is_illegal) begin
          illegal = 1'b1;
        end else begin
          nxt_state = S_EXE;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        if (is_branch) begin
          aluc     = ALUC_SUB;
          pcsource = PC_BRANCH;
          wpc      = is_bne ? ~z : z;
        end else if (is_lw || is_sw) begin
          alusrcb   = SRCB_IMM;
          nxt_state = S_MEM;
        end else if (is_rtype || is_shift) begin
          aluc      = dec_aluc;
          shift     = is_shift;
          nxt_state = S_WB;
        end else if (is_itype) begin
          alusrcb   = SRCB_IMM;
          aluc      = dec_aluc;
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (mem_ready) begin
          wmem      = is_sw;
          nxt_state = is_lw ? S_WB : S_IF;
        end else if (timeout) begin
          bus_err = 1'b1;
        end else begin
          wmem      = is_sw;
          nxt_state = S_MEM;
          cnt_nxt   = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        wreg  = 1'b1;
        regrt = is_itype || is_lw;
        m2reg = is_lw;
      end
      default: ;
    endcase
    // Reset must abort any write in flight, even mid-cycle.
    if (rst) begin
      wpc     = 1'b0;
      wir     = 1'b0;
      wmem    = 1'b0;
      wreg    = 1'b0;
      bus_err = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_control_multi.sv
// Directed bench for cpu_control_multi: stimulus pushes hand-derived per-cycle
// control vectors into a queue, a negedge monitor pops and compares them.
module tb_cpu_control_multi;

  typedef struct packed {
    logic [2:0] state;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic       bus_err, illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst, z, mem_ready;
  logic [5:0] op, fun;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;
  logic       bus_err, illegal;

  ctl_t  act;
  ctl_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  logic [5:0] cur_op, cur_fun;

  cpu_control_multi #(.MEM_WAIT_MAX(3)) dut (
    .clk(clk), .rst(rst), .op(op), .fun(fun), .z(z), .mem_ready(mem_ready),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .sext(sext), .shift(shift), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state),
    .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
                alusrca, alusrcb, aluc, pcsource, bus_err, illegal};

  always @(negedge clk) begin
    ctl_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t, act, act.state, e, e.state);
    end
  end

  function automatic ctl_t base(input logic [2:0] st, input logic sx);
    ctl_t e;
    e = '0;
    e.state = st;
    e.sext = sx;
    return e;
  endfunction

  function automatic ctl_t e_if(input logic mr, input logic sx);
    ctl_t e;
    e = base(3'd0, sx);
    e.alusrcb = 2'b01;
    e.wir = mr;
    e.wpc = mr;
    return e;
  endfunction

  function automatic ctl_t e_id(input logic sx);
    ctl_t e;
    e = base(3'd1, sx);
    e.alusrcb = 2'b11;
    return e;
  endfunction

  function automatic ctl_t e_exe(input logic sx);
    ctl_t e;
    e = base(3'd2, sx);
    e.alusrca = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_mem(input logic sx);
    ctl_t e;
    e = base(3'd3, sx);
    e.iord = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_wb(input logic sx);
    ctl_t e;
    e = base(3'd4, sx);
    e.wreg = 1'b1;
    return e;
  endfunction

  task automatic push(input string t, input ctl_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic step(input string t, input logic mr, input logic zf, input ctl_t e);
    @(posedge clk);
    #1;
    op = cur_op;
    fun = cur_fun;
    mem_ready = mr;
    z = zf;
    push(t, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t e;
    rst = 1'b1; mem_ready = 1'b1; z = 1'b0; op = 6'h00; fun = 6'h20;
    cur_op = 6'h00; cur_fun = 6'h20;
    #2 push("reset", e_if(1'b0, 1'b0));
    @(negedge clk);
    mem_ready = 1'b0;
    #2 rst = 1'b0;

    // add
    step("add.if", 1, 0, e_if(1'b1, 1'b0));
    step("add.id", 1, 0, e_id(1'b0));
    step("add.exe", 1, 0, e_exe(1'b0));
    step("add.wb", 1, 0, e_wb(1'b0));

    // sll
    cur_fun = 6'h00;
    step("sll.if", 1, 0, e_if(1'b1, 1'b0));
    step("sll.id", 1, 0, e_id(1'b0));
    e = e_exe(1'b0); e.shift = 1'b1; e.aluc = 4'b0011;
    step("sll.exe", 1, 0, e);
    step("sll.wb", 1, 0, e_wb(1'b0));

    // andi (zero-extended)
    cur_op = 6'h0C;
    step("andi.if", 1, 0, e_if(1'b1, 1'b0));
    step("andi.id", 1, 0, e_id(1'b0));
    e = e_exe(1'b0); e.alusrcb = 2'b10; e.aluc = 4'b0001;
    step("andi.exe", 1, 0, e);
    e = e_wb(1'b0); e.regrt = 1'b1;
    step("andi.wb", 1, 0, e);

    // lw with three wait cycles in MEM; ready arrives as wait_cnt hits the limit
    cur_op = 6'h23;
    step("lw.if", 1, 0, e_if(1'b1, 1'b1));
    step("lw.id", 1, 0, e_id(1'b1));
    e = e_exe(1'b1); e.alusrcb = 2'b10;
    step("lw.exe", 1, 0, e);
    for (int i = 0; i < 3; i++) step("lw.memwait", 0, 0, e_mem(1'b1));
    step("lw.memdone", 1, 0, e_mem(1'b1));
    e = e_wb(1'b1); e.regrt = 1'b1; e.m2reg = 1'b1;
    step("lw.wb", 1, 0, e);

    // beq/bne with both z values
    for (int k = 0; k < 4; k++) begin
      cur_op = (k < 2) ? 6'h04 : 6'h05;
      step("br.if", 1, 0, e_if(1'b1, 1'b1));
      step("br.id", 1, 0, e_id(1'b1));
      e = e_exe(1'b1); e.aluc = 4'b0100; e.pcsource = 2'b01;
      e.wpc = (k == 0) || (k == 2);
      step(k == 0 ? "beq.z1" : k == 1 ? "beq.z0" : k == 2 ? "bne.z0" : "bne.z1",
           1, (k == 0) || (k == 3), e);
    end

    // jal, j, jr resolve in ID
    cur_op = 6'h03;
    step("jal.if", 1, 0, e_if(1'b1, 1'b0));
    e = e_id(1'b0); e.wpc = 1'b1; e.pcsource = 2'b11; e.wreg = 1'b1; e.jal = 1'b1;
    step("jal.id", 1, 0, e);
    cur_op = 6'h02;
    step("j.if", 1, 0, e_if(1'b1, 1'b0));
    e = e_id(1'b0); e.wpc = 1'b1; e.pcsource = 2'b11;
    step("j.id", 1, 0, e);
    cur_op = 6'h00; cur_fun = 6'h08;
    step("jr.if", 1, 0, e_if(1'b1, 1'b0));
    e = e_id(1'b0); e.wpc = 1'b1; e.pcsource = 2'b10;
    step("jr.id", 1, 0, e);

    // sw with one wait cycle
    cur_op = 6'h2B;
    step("sw.if", 1, 0, e_if(1'b1, 1'b1));
    step("sw.id", 1, 0, e_id(1'b1));
    e = e_exe(1'b1); e.alusrcb = 2'b10;
    step("sw.exe", 1, 0, e);
    e = e_mem(1'b1); e.wmem = 1'b1;
    step("sw.memwait", 0, 0, e);
    step("sw.memdone", 1, 0, e);

    // IF timeout twice (counter must restart), then ready on the limit cycle
    cur_op = 6'h00; cur_fun = 6'h20;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) step("ifto.wait", 0, 0, e_if(1'b0, 1'b0));
      e = e_if(1'b0, 1'b0); e.bus_err = 1'b1;
      step("ifto.buserr", 0, 0, e);
    end
    for (int i = 0; i < 3; i++) step("ifok.wait", 0, 0, e_if(1'b0, 1'b0));
    step("ifok.ready", 1, 0, e_if(1'b1, 1'b0));
    step("ifok.id", 1, 0, e_id(1'b0));
    step("ifok.exe", 1, 0, e_exe(1'b0));
    step("ifok.wb", 1, 0, e_wb(1'b0));

    // sw MEM timeout: no wmem on the bus_err cycle
    cur_op = 6'h2B;
    step("swto.if", 1, 0, e_if(1'b1, 1'b1));
    step("swto.id", 1, 0, e_id(1'b1));
    e = e_exe(1'b1); e.alusrcb = 2'b10;
    step("swto.exe", 1, 0, e);
    e = e_mem(1'b1); e.wmem = 1'b1;
    for (int i = 0; i < 3; i++) step("swto.wait", 0, 0, e);
    e = e_mem(1'b1); e.bus_err = 1'b1;
    step("swto.buserr", 0, 0, e);
    step("swto.ret", 1, 0, e_if(1'b1, 1'b1));

    // reset mid-sw in MEM
    step("swrst.id", 1, 0, e_id(1'b1));
    e = e_exe(1'b1); e.alusrcb = 2'b10;
    step("swrst.exe", 1, 0, e);
    e = e_mem(1'b1); e.wmem = 1'b1;
    step("swrst.mem", 0, 0, e);
    @(posedge clk);
    #1 mem_ready = 1'b0;
    #1 rst = 1'b1;
    push("rst.mid", e_if(1'b0, 1'b1));
    @(posedge clk);
    #1 mem_ready = 1'b1;
    push("rst.hold", e_if(1'b0, 1'b1));
    @(negedge clk);
    #1 mem_ready = 1'b0;
    #1 rst = 1'b0;

    // undecoded opcode
    cur_op = 6'h3F;
    step("ill.if", 1, 0, e_if(1'b1, 1'b0));
    e = e_id(1'b0); e.illegal = 1'b1;
    step("ill.id", 1, 0, e);
    step("ill.ret", 0, 0, e_if(1'b0, 1'b0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
